pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised pipeline stage register, the successor to the plain clocked stage register between MIPS pipeline stages. It carries a `WIDTH`-bit stage bundle with a valid/ready handshake. It supports back-pressure (stall), synchronous flush to a bubble value, and an optional skid entry so that `in_ready` does not depend combinationally on `out_ready`. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- `WIDTH`, 32: width of the stage bundle (typically `$bits` of the stage struct).
- `BUBBLE_VALUE`, `'0`: value loaded into data registers on reset and flush (a NOP bundle).
- `SKID`, 1: 1 adds a second (skid) entry and registered `in_ready`; 0 is a single entry with combinational ready pass-through.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset (asserted when 0).
- `flush`, in, 1: synchronous flush; squashes all held entries.
- `in_valid`, in, 1: upstream has a bundle.
- `in_ready`, out, 1: stage accepts the bundle this cycle.
- `in_data`, in, `WIDTH`: upstream bundle.
- `out_valid`, out, 1: `out_data` holds a live bundle.
- `out_ready`, in, 1: downstream accepts this cycle.
- `out_data`, out, `WIDTH`: head bundle.
- `occupancy`, out, 2: number of live entries (0..2).

## Operation
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Storage:
  - `main` register with valid bit; drives `out_data` and `out_valid`.
  - `skid` register with valid bit (`SKID=1` only).
- States, encoded by (main valid, skid valid):
  - EMPTY: 0 entries.
  - ONE: 1 entry.
  - FULL: 2 entries, `SKID=1` only.
- Transitions when not in reset and `flush=0`:
  - EMPTY + in fire -> ONE, main <= `in_data`.
  - ONE + in fire + out fire -> ONE, main <= `in_data`.
  - ONE + in fire, no out fire -> FULL (`SKID=1`), skid <= `in_data`.
  - ONE + out fire, no in fire -> EMPTY; main data holds its stale value.
  - FULL + out fire -> ONE, main <= skid; skid data holds.
  - Any other combination -> hold.
- `in_ready`:
  - `SKID=1`: `reset && !skid_valid`, i.e. a register output gated only by reset.
  - `SKID=0`: `reset && (!main_valid || out_ready)`. FULL is unreachable.
- Ordering: strict FIFO; a bundle is never duplicated or dropped except by flush.
- Flush (priority below reset, above everything else):
  - Next state is EMPTY.
  - main and skid data <= `BUBBLE_VALUE`.
  - An input fire in the flush cycle is discarded.
  - An output fire in the flush cycle counts as completed downstream.
- Reset (`reset=0` at an edge):
  - Next state is EMPTY.
  - Data <= `BUBBLE_VALUE`.
  - `in_ready=0` while `reset=0`.
  - Reset mid-transfer discards all entries.
- `occupancy` = main_valid + skid_valid, registered state.

## Timing
- Reset values: `out_valid=0`, `out_data=BUBBLE_VALUE`, `occupancy=0`, `in_ready=0` during reset and 1 in the first cycle after release.
- Latency: an input fire at edge N makes data visible on `out_data` with `out_valid=1` after edge N; this is 1 cycle.
- Throughput: 1 bundle/cycle while `out_ready=1`, in both `SKID` modes.
- `SKID=1` back-pressure:
  - `out_ready` falling while ONE absorbs exactly one more bundle into skid.
  - `in_ready` drops the cycle after FULL is reached.
  - `in_ready` rises the cycle after the output fire that leaves FULL.
- `out_data` stays stable while `out_valid=1 && out_ready=0`.
- Only the flush and reset controls act at the next edge; neither has any combinational effect on outputs, except reset gating `in_ready`.

## Test plan
- Reset release, `SKID=1`, `WIDTH=32`, `BUBBLE_VALUE=32'h0000_0013` -> `out_valid=0`, `out_data=32'h13`, `occupancy=0` during reset; `in_ready=1` on the first cycle after.
- Streaming: `out_ready=1`, `in_valid=1`, data 1,2,3,4 on consecutive cycles -> `out_data` shows 1,2,3,4 on the following consecutive cycles with `out_valid=1`; `occupancy` stays at 1.
- Stall, `SKID=1`: load 0xA; drop `out_ready`; present 0xB then 0xC:
  - 0xB enters skid, `occupancy=2`, `in_ready=0`, and 0xC is held upstream.
  - Raising `out_ready` yields 0xA, 0xB, 0xC in order with no loss.
- Flush while FULL, with a simultaneous input fire of 0xD -> next cycle `occupancy=0`, `out_valid=0`, `out_data=BUBBLE_VALUE`; 0xD never appears.
- `SKID=0`: `out_valid=1`, `out_ready=0` -> `in_ready=0` in the same cycle; `out_ready=1` -> `in_ready=1` in the same cycle, with a simultaneous pop and push.
- Reset asserted while FULL -> next cycle `occupancy=0`; after release the first bundle accepted emerges 1 cycle later.

Source files
------------

// File: rtl/pipeline_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg_if
//   Handshake bundle for one pipeline stage register. It groups the upstream
//   side (in_*), the downstream side (out_*), the flush control and the
//   occupancy status.
//
//   modport slave  : the view the stage register uses.
//                    Inputs:  flush, in_valid, in_data, out_ready.
//                    Outputs: in_ready, out_valid, out_data, occupancy.
//   modport master : the view of whatever surrounds the stage, with every
//                    direction reversed.
// ---------------------------------------------------------------------------
interface pipeline_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg
//   Stage register placed between two pipeline stages. It carries a
//   WIDTH-bit stage bundle under a valid/ready handshake and supports
//   back-pressure, synchronous flush to BUBBLE_VALUE, and an optional skid
//   entry. With the skid entry, in_ready is a registered signal and does not
//   depend combinationally on out_ready.
//
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : pipeline_stage_reg_if.slave
//             (flush, in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data, occupancy)
//
//   Parameters:
//     WIDTH        : bundle width
//     BUBBLE_VALUE : value loaded into the data registers on reset or flush
//     SKID         : 1 = two entries with registered in_ready,
//                    0 = one entry with ready passed straight through
// ---------------------------------------------------------------------------
module pipeline_stage_reg #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int unsigned      SKID         = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_stage_reg_if.slave  bus
);

    // The encoding is (main valid, skid valid), so each valid bit reads
    // directly out of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic main_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign main_valid = state_q[1];

    generate
        if (SKID != 0) begin : g_skid
            // Depends only on registered state and reset; out_ready is not involved.
            assign in_ready = reset && (state_q != FULL);
        end else begin : g_noskid
            // With a single entry, a slot frees up in the same cycle the head leaves.
            assign in_ready = reset && (!main_valid || bus.out_ready);
        end
    endgenerate

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = main_valid && bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset || bus.flush) begin
            // Any output fire in a flush cycle has already completed downstream,
            // and any input fire in that cycle is discarded.
            state_q <= EMPTY;
            main_q  <= BUBBLE_VALUE;
            skid_q  <= BUBBLE_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        main_q  <= bus.in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= bus.in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        // The head is stalled, so the new bundle parks in skid.
                        state_q <= FULL;
                        skid_q  <= bus.in_data;
                    end else if (out_fire) begin
                        // main_q keeps its stale value; out_valid masks it.
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = {1'b0, state_q[1]} + {1'b0, state_q[0]};

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipeline_stage_reg_if #(.WIDTH(32)) b1();
    pipeline_stage_reg_if #(.WIDTH(32)) b0();

    pipeline_stage_reg #(
        .WIDTH        (32),
        .BUBBLE_VALUE (32'h0000_0013),
        .SKID         (1)
    ) dut1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (b1)
    );

    pipeline_stage_reg #(
        .WIDTH (32),
        .SKID  (0)
    ) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (b0)
    );

    logic [31:0] q1[$];
    logic [31:0] q0[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample the handshakes, update the scoreboards,
    // take the edge, then settle 1 time unit past it.
    task automatic step();
        logic [31:0] e;
        #1;
        if (b1.out_valid && b1.out_ready) begin
            tests++;
            assert (q1.size() > 0) else begin
                fails++;
                $error("FAIL sb1_extra observed=%h expected=none", b1.out_data);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sb1_data", b1.out_data, e);
            end
        end
        if (b1.in_valid && b1.in_ready) q1.push_back(b1.in_data);
        if (!rst_n || b1.flush) q1.delete();

        if (b0.out_valid && b0.out_ready) begin
            tests++;
            assert (q0.size() > 0) else begin
                fails++;
                $error("FAIL sb0_extra observed=%h expected=none", b0.out_data);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("sb0_data", b0.out_data, e);
            end
        end
        if (b0.in_valid && b0.in_ready) q0.push_back(b0.in_data);
        if (!rst_n || b0.flush) q0.delete();

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        b0.flush = 1'b0; b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("rst_out_data", b1.out_data, 32'h13);
        chk("rst_occupancy", {30'd0, b1.occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, b1.in_ready}, 32'd0);
        chk("rst0_out_data", b0.out_data, 32'd0);
        chk("rst0_in_ready", {31'd0, b0.in_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, b1.in_ready}, 32'd1);
        chk("post_rst0_in_ready", {31'd0, b0.in_ready}, 32'd1);

        // Streaming at full throughput, both variants
        b1.out_ready = 1'b1;
        b0.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b1.in_valid = 1'b1; b1.in_data = 32'(i);
            b0.in_valid = 1'b1; b0.in_data = 32'(i);
            if (i > 1) begin
                chk("stream_out_valid", {31'd0, b1.out_valid}, 32'd1);
                chk("stream_out_data", b1.out_data, 32'(i - 1));
                chk("stream_occ", {30'd0, b1.occupancy}, 32'd1);
                chk("stream0_out_data", b0.out_data, 32'(i - 1));
                chk("stream0_in_ready", {31'd0, b0.in_ready}, 32'd1);
            end
            step();
        end
        b1.in_valid = 1'b0;
        b0.in_valid = 1'b0;
        chk("stream_last", b1.out_data, 32'd4);
        step();
        chk("stream_empty_occ", {30'd0, b1.occupancy}, 32'd0);
        chk("stream0_empty", {31'd0, b0.out_valid}, 32'd0);

        // Stall with skid entry
        b1.out_ready = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 32'hA;
        step();
        chk("stall_occ1", {30'd0, b1.occupancy}, 32'd1);
        b1.in_data = 32'hB;
        chk("stall_rdy_one", {31'd0, b1.in_ready}, 32'd1);
        step();
        chk("stall_occ2", {30'd0, b1.occupancy}, 32'd2);
        chk("stall_rdy_full", {31'd0, b1.in_ready}, 32'd0);
        chk("stall_head", b1.out_data, 32'hA);
        b1.in_data = 32'hC;
        step();
        chk("stall_hold_occ", {30'd0, b1.occupancy}, 32'd2);
        chk("stall_stable", b1.out_data, 32'hA);
        b1.out_ready = 1'b1;
        step();
        chk("unstall_occ", {30'd0, b1.occupancy}, 32'd1);
        chk("unstall_rdy", {31'd0, b1.in_ready}, 32'd1);
        chk("unstall_head", b1.out_data, 32'hB);
        step();
        chk("unstall_c", b1.out_data, 32'hC);
        b1.in_valid = 1'b0;
        step();
        chk("unstall_empty", {30'd0, b1.occupancy}, 32'd0);

        // Flush in ONE with a real input fire
        b1.out_ready = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 32'h21;
        step();
        b1.in_data = 32'hD; b1.flush = 1'b1;
        #1;
        chk("flush1_fire_rdy", {31'd0, b1.in_ready}, 32'd1);
        step();
        b1.flush = 1'b0; b1.in_valid = 1'b0;
        chk("flush1_occ", {30'd0, b1.occupancy}, 32'd0);
        chk("flush1_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("flush1_data", b1.out_data, 32'h13);

        // Flush while FULL
        b1.in_valid = 1'b1; b1.in_data = 32'h22;
        step();
        b1.in_data = 32'h23;
        step();
        chk("flush2_pre_occ", {30'd0, b1.occupancy}, 32'd2);
        b1.in_data = 32'hD; b1.flush = 1'b1;
        step();
        b1.flush = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        chk("flush2_occ", {30'd0, b1.occupancy}, 32'd0);
        chk("flush2_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("flush2_data", b1.out_data, 32'h13);
        step();
        chk("flush2_no_d", {31'd0, b1.out_valid}, 32'd0);

        // SKID=0: ready follows out_ready in the same cycle
        b0.out_ready = 1'b0;
        b0.in_valid = 1'b1; b0.in_data = 32'h51;
        step();
        b0.in_data = 32'h52;
        #1;
        chk("s0_rdy_low", {31'd0, b0.in_ready}, 32'd0);
        b0.out_ready = 1'b1;
        #1;
        chk("s0_rdy_high", {31'd0, b0.in_ready}, 32'd1);
        step();
        chk("s0_swap_data", b0.out_data, 32'h52);
        chk("s0_swap_occ", {30'd0, b0.occupancy}, 32'd1);
        b0.in_valid = 1'b0;
        step();
        chk("s0_empty", {30'd0, b0.occupancy}, 32'd0);

        // Reset while FULL
        b1.out_ready = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 32'h31;
        step();
        b1.in_data = 32'h32;
        step();
        chk("rfull_pre_occ", {30'd0, b1.occupancy}, 32'd2);
        b1.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rfull_occ", {30'd0, b1.occupancy}, 32'd0);
        chk("rfull_rdy", {31'd0, b1.in_ready}, 32'd0);
        chk("rfull_data", b1.out_data, 32'h13);
        rst_n = 1'b1;
        b1.in_valid = 1'b1; b1.in_data = 32'h41; b1.out_ready = 1'b1;
        step();
        b1.in_valid = 1'b0;
        chk("rfull_lat_valid", {31'd0, b1.out_valid}, 32'd1);
        chk("rfull_lat_data", b1.out_data, 32'h41);
        step();
        chk("rfull_end_occ", {30'd0, b1.occupancy}, 32'd0);

        // Bounded drain of anything still expected
        b1.out_ready = 1'b1;
        b0.out_ready = 1'b1;
        for (int n = 0; n < 8 && (q1.size() > 0 || q0.size() > 0); n++) step();
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q0", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
